// File: rtl/gnrl_pipe_stage.sv
// Pipeline register slice with valid/ready flow control, synchronous flush and
// an optional 2-entry skid buffer that keeps in_ready registered at full throughput.
module gnrl_pipe_stage #(
  parameter int DW   = 32,
  parameter int SKID = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] data_ini,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic [1:0]    occ
);

  // State value equals the occupancy count, so occ comes straight off the register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  if (SKID != 0) begin : g_skid

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_d  = data_in;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = data_in;
          end else if (push) begin
            skid_d  = data_in;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      // Flush kills any handshake of this cycle but leaves the data registers untouched.
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        // NOTE: the data registers are reset here because data_ini defines a known head value.
        state_q     <= EMPTY;
        main_q      <= data_ini;
        skid_q      <= data_ini;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        state_q     <= state_d;
        main_q      <= main_d;
        skid_q      <= skid_d;
        out_valid_q <= out_valid_d;
        in_ready_q  <= in_ready_d;
      end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = main_q;
    assign occ       = state_q;

  end else begin : g_single

    logic [DW-1:0] main_q;
    logic          vld_q;
    logic          push, pop;

    // Accept whenever the slot is empty or is being drained this same cycle.
    assign in_ready = !vld_q || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = vld_q && out_ready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        main_q <= data_ini;
        vld_q  <= 1'b0;
      end else if (flush) begin
        vld_q  <= 1'b0;
      end else if (push) begin
        main_q <= data_in;
        vld_q  <= 1'b1;
      end else if (pop) begin
        vld_q  <= 1'b0;
      end
    end

    assign out_valid = vld_q;
    assign data_out  = main_q;
    assign occ       = {1'b0, vld_q};

  end

endmodule

// File: tb/tb_gnrl_pipe_stage.sv
// Bench for gnrl_pipe_stage: one skid instance and one single-entry instance,
// each with a queue scoreboard plus table-driven and hand-written sequences.
module tb_gnrl_pipe_stage;

  localparam int DW = 32;
  localparam logic [DW-1:0] INI = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_ini;

  // SKID=1 instance signals
  logic          flush, in_valid, out_ready;
  logic [DW-1:0] data_in;
  logic          in_ready, out_valid;
  logic [DW-1:0] data_out;
  logic [1:0]    occ;

  // SKID=0 instance signals
  logic          s_flush, s_in_valid, s_out_ready;
  logic [DW-1:0] s_data_in;
  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_data_out;
  logic [1:0]    s_occ;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb1[$];
  logic [DW-1:0] sb0[$];

  always #5 clk = ~clk;

  gnrl_pipe_stage #(.DW(DW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_ini(data_ini),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .occ(occ)
  );

  gnrl_pipe_stage #(.DW(DW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .data_ini(data_ini),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .data_in(s_data_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .data_out(s_data_out), .occ(s_occ)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_skid(input string tag, input logic ov, input logic [DW-1:0] d,
                            input logic [1:0] o, input logic ir);
    check({tag, "_out_valid"}, DW'(out_valid), DW'(ov));
    check({tag, "_data_out"},  data_out, d);
    check({tag, "_occ"},       DW'(occ), DW'(o));
    check({tag, "_in_ready"},  DW'(in_ready), DW'(ir));
  endtask

  // Scoreboards: sample handshakes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb1.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb1.size() == 0) check("sb1_unexpected_out", DW'(out_valid), '0);
        else check("sb1_data", data_out, sb1.pop_front());
      end
      if (in_valid && in_ready) sb1.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (!rst_n || s_flush) begin
      sb0.delete();
    end else begin
      if (s_out_valid && s_out_ready) begin
        if (sb0.size() == 0) check("sb0_unexpected_out", DW'(s_out_valid), '0);
        else check("sb0_data", s_data_out, sb0.pop_front());
      end
      if (s_in_valid && s_in_ready) sb0.push_back(s_data_in);
    end
  end

  typedef struct packed {
    logic          iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic [DW-1:0] dout;
    logic [1:0]    occ;
    logic          ir;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      // back-pressure: fill to FULL, hold (incoming beats refused), then drain
      '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1},
      '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0},
      '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1},
      '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h22, 2'd0, 1'b1},
      // flush in FULL with both handshakes offered
      '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44, 2'd1, 1'b1},
      '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b0},
      '{1'b1, 32'h66, 1'b1, 1'b1, 1'b0, 32'h44, 2'd0, 1'b1},
      '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h44, 2'd0, 1'b1},
      // simultaneous push and pop in ONE
      '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 32'h77, 2'd1, 1'b1},
      '{1'b1, 32'h88, 1'b1, 1'b0, 1'b1, 32'h88, 2'd1, 1'b1},
      '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h88, 2'd0, 1'b1}
    };

    rst_n = 1'b0; data_ini = INI;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_data_in = '0;

    // Reset
    step(); step();
    check_skid("reset", 1'b0, INI, 2'd0, 1'b1);
    check("reset0_data_out", s_data_out, INI);
    check("reset0_out_valid", DW'(s_out_valid), '0);
    check("reset0_occ", DW'(s_occ), '0);
    check("reset0_in_ready", DW'(s_in_ready), DW'(1));
    rst_n = 1'b1;

    // Streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; data_in = DW'(i);
      step();
      check_skid($sformatf("stream%0d", i), 1'b1, DW'(i), 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check_skid("stream_end", 1'b0, DW'(8), 2'd0, 1'b1);

    // Table: back-pressure, flush, simultaneous transfer
    for (int i = 0; i < 16; i++) begin
      in_valid = vecs[i].iv; data_in = vecs[i].din;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      step();
      check_skid($sformatf("vec%0d", i), vecs[i].ov, vecs[i].dout, vecs[i].occ, vecs[i].ir);
    end
    flush = 1'b0; out_ready = 1'b0;

    // Reset while FULL with a pending input
    in_valid = 1'b1; data_in = 32'hA1; step();
    data_in = 32'hA2; step();
    check_skid("prefull", 1'b1, 32'hA1, 2'd2, 1'b0);
    rst_n = 1'b0; data_in = 32'hA3; step();
    check_skid("midreset", 1'b0, INI, 2'd0, 1'b1);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; step();
    check_skid("postreset", 1'b0, INI, 2'd0, 1'b1);

    // SKID=0: combinational in_ready and same-cycle replacement
    s_in_valid = 1'b1; s_data_in = 32'h44; step();
    s_in_valid = 1'b0; #1;
    check("s0_hold_out_valid", DW'(s_out_valid), DW'(1));
    check("s0_hold_data", s_data_out, 32'h44);
    check("s0_hold_in_ready", DW'(s_in_ready), '0);
    s_out_ready = 1'b1; #1;
    check("s0_comb_in_ready", DW'(s_in_ready), DW'(1));
    s_in_valid = 1'b1; s_data_in = 32'h55; step();
    check("s0_swap_data", s_data_out, 32'h55);
    check("s0_swap_out_valid", DW'(s_out_valid), DW'(1));
    check("s0_swap_occ", DW'(s_occ), DW'(1));
    s_in_valid = 1'b0; step();
    check("s0_drain_out_valid", DW'(s_out_valid), '0);
    check("s0_drain_occ", DW'(s_occ), '0);

    // SKID=0 flush discards the held entry and the same-cycle input
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_data_in = 32'h66; step();
    s_flush = 1'b1; s_data_in = 32'h77; step();
    s_flush = 1'b0; s_in_valid = 1'b0;
    check("s0_flush_out_valid", DW'(s_out_valid), '0);
    check("s0_flush_data", s_data_out, 32'h66);
    check("s0_flush_occ", DW'(s_occ), '0);
    step();

    check("sb1_residual", DW'(sb1.size()), '0);
    check("sb0_residual", DW'(sb0.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gnrl_pipe_stage.md
Name: gnrl_pipe_stage

Overview:
- Parametrised pipeline register slice with a valid/ready handshake on both sides; successor to the plain write-enabled DFF.
- Adds flow control, a synchronous flush, an optional 2-entry skid buffer (registered in_ready, full throughput) and an occupancy output.
- Sits between core pipeline stages (IF/ID/EX) and on bus boundaries where back-pressure must be absorbed without dropping data.

Parameters:
- DW, 32, data width in bits.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single-entry stage with combinational in_ready.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous flush; discards all held entries.
- data_ini  input  DW  value loaded into the data registers on reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready.
- data_in  input  DW  upstream data.
- out_valid  output  1  stage holds valid data.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready.
- data_out  output  DW  head-entry data (main register).
- occ  output  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
Reset and priority:
- Reset is sampled on posedge clk only.
- Reset values: main and skid data = data_ini; out_valid = 0; occ = 0; in_ready = 1 (SKID=1, registered).
- Priority per edge: reset > flush > handshake updates.

Flush:
- Clears all valid bits and sets occ = 0. SKID=1: in_ready <= 1.
- Data registers keep their value.
- Any input or output handshake completing in the flush cycle is discarded. Upstream and downstream must treat it as killed.

All outputs:
- All outputs are driven from registers, except in_ready when SKID=0.
- Registered outputs are stable while no handshake occurs; data_out never changes while out_valid && !out_ready.

SKID=0 (single entry):
- in_ready = !out_valid || out_ready (combinational).
- On an input transfer: main <= data_in, out_valid <= 1.
- Output transfer without an input transfer: out_valid <= 0.
- Simultaneous in/out transfer: new data loaded, out_valid stays 1; full throughput.
- Latency: 1 cycle from input transfer to out_valid.

SKID=1 state machine, encoded by occ (main valid, skid valid):
- EMPTY (occ 0): in_ready = 1. Input transfer -> main <= data_in -> ONE.
- ONE (occ 1): in_ready = 1.
  - Input transfer and output transfer: main <= data_in, stay ONE.
  - Input transfer only: skid <= data_in -> FULL; in_ready <= 0.
  - Output transfer only: -> EMPTY.
- FULL (occ 2): in_ready = 0. No input transfer is possible.
  - Output transfer: main <= skid -> ONE; in_ready <= 1.
- in_ready is exactly !FULL and comes from a flop, with no combinational path from out_ready.
- Ordering: FIFO order is always preserved; no data is duplicated or dropped except on flush or reset.
- Latency: 1 cycle in EMPTY. Sustained throughput is 1 transfer/cycle with out_ready held high.
- Illegal occ value 3 never occurs; if forced, the implementation recovers to EMPTY on the next edge.

Stall:
- out_ready = 0 with out_valid = 1 holds data_out and out_valid unchanged for an arbitrary number of cycles.

Test Plan:
1. Reset: data_ini=32'hDEAD_BEEF, rst_n low 2 cycles -> data_out=32'hDEAD_BEEF, out_valid=0, occ=0, in_ready=1.
2. Streaming (SKID=1): out_ready=1, in_valid=1 with data 1..8 on consecutive cycles -> out_valid rises 1 cycle after the first beat; data_out=1..8 on consecutive cycles; occ stays 1; in_ready stays 1.
3. Back-pressure (SKID=1): out_ready=0, push A=0x11, B=0x22 -> occ=2, in_ready=0 on the cycle after B, data_out=0x11. Hold out_ready=0 for 5 cycles -> no change. Raise out_ready -> 0x11 then 0x22 delivered, occ 2->1->0, in_ready returns to 1 after the first pop.
4. Flush in FULL with in_valid=1 and out_ready=1 in the same cycle -> next cycle occ=0, out_valid=0, in_ready=1; neither beat is observed downstream.
5. SKID=0: out_ready=0 with one entry held -> in_ready=0 combinationally. Raise out_ready with in_valid=1, data 0x55 -> same-cycle accept, data_out=0x55 next cycle, out_valid stays 1.
6. Reset mid-operation: rst_n low in FULL with in_valid=1 -> next edge occ=0, data_out=data_ini, out_valid=0; the pending input is not captured.
